// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// mux_scan_pkg : shared types and sizes for the 4-channel mux scan controller
// Rev 1.0
// ============================================================================
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    // ST_ prefix keeps the state names clear of the module's SETTLE parameter
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic is_last_ch(input logic [SEL_W-1:0] ch);
        return ch == SEL_W'(NUM_CH - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// mux_scan_ctrl_if : start/select/sample/result handshake bundle
// Rev 1.0
// ============================================================================
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic              start;
    logic              s0;
    logic              s1;
    logic              f;
    logic [NUM_CH-1:0] data_out;
    logic              valid;
    logic              ready;
    logic              busy;

    // master: the scan controller; slave: the mux stage and result consumer
    modport master (
        input  start, f, ready,
        output s0, s1, data_out, valid, busy
    );

    modport slave (
        output start, f, ready,
        input  s0, s1, data_out, valid, busy
    );

endinterface
`default_nettype wire

// File: rtl/mux_scan_settle_cnt.sv
`default_nettype none
// ============================================================================
// mux_scan_settle_cnt : settle-time down-counter, saturates at zero
// Rev 1.0
// ============================================================================
module mux_scan_settle_cnt
    import mux_scan_pkg::*;
#(
    parameter logic [CNT_W-1:0] LOAD_VAL = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= LOAD_VAL;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// mux_scan_ctrl : steps a 4:1 mux select, samples f per channel after a
//                 settle delay and hands the 4-bit result over valid/ready
// Rev 1.0
// ============================================================================
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_scan_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] c_settle_load = CNT_W'(SETTLE - 1);

    state_t            r_state;
    state_t            w_next;
    logic [SEL_W-1:0]  r_ch;
    logic [NUM_CH-1:0] r_shadow;
    logic [NUM_CH-1:0] r_data;
    logic [NUM_CH-1:0] w_shadow_upd;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_zero;
    logic              w_scan_start;
    logic              w_sample;
    logic              w_last;

    mux_scan_settle_cnt #(
        .LOAD_VAL (c_settle_load)
    ) u_settle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_cnt_load),
        .dec   (w_cnt_dec),
        .zero  (w_cnt_zero)
    );

    assign w_last = is_last_ch(r_ch);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_scan_start = 1'b0;
        w_sample     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next       = ST_SETTLE;
                    w_scan_start = 1'b1;
                    w_cnt_load   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_cnt_zero) begin
                    w_next = ST_SAMPLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                w_sample = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next     = ST_SETTLE;
                    w_cnt_load = 1'b1;
                end
            end
            ST_DONE: begin
                // start is only honoured on the edge that consumes the result
                if (bus.ready) begin
                    if (bus.start) begin
                        w_next       = ST_SETTLE;
                        w_scan_start = 1'b1;
                        w_cnt_load   = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_shadow_upd       = r_shadow;
        w_shadow_upd[r_ch] = bus.f;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ch     <= '0;
            r_shadow <= '0;
            r_data   <= '0;
        end else begin
            if (w_scan_start) begin
                r_ch <= '0;
            end else if (w_sample && !w_last) begin
                r_ch <= r_ch + SEL_W'(1);
            end
            if (w_sample) begin
                r_shadow <= w_shadow_upd;
                if (w_last) begin
                    r_data <= w_shadow_upd;
                end
            end
        end
    end

    assign bus.s0       = r_ch[0];
    assign bus.s1       = r_ch[1];
    assign bus.data_out = r_data;
    assign bus.valid    = (r_state == ST_DONE);
    assign bus.busy     = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mux_scan_ctrl : directed bench for mux_scan_ctrl with a 4:1 mux feedback
// Rev 1.0
// ============================================================================
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] in1;
    logic [3:0] in3;
    int         checks;
    int         errors;

    mux_scan_ctrl_if bus1 ();
    mux_scan_ctrl_if bus3 ();

    mux_scan_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mux_scan_ctrl #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    // 4:1 mux stage downstream of the selects, output fed back to f
    function automatic logic mux4(input logic [3:0] d, input logic s1, input logic s0);
        return d[{s1, s0}];
    endfunction

    assign bus1.f = mux4(in1, bus1.s1, bus1.s0);
    assign bus3.f = mux4(in3, bus3.s1, bus3.s0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       start;
        logic       ready;
        logic [1:0] sel;
        logic       busy;
        logic       valid;
        logic [3:0] data;
    } vec_t;

    vec_t tbl [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        int   t_v1;
        int   t_v2;
        int   pulses;
        int   wide;
        logic prev_v;
        logic [3:0] d_seen;

        checks = 0;
        errors = 0;

        // scan with i0..i3 = 1,0,1,1, then 5 cycles of backpressure with two start pulses
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000};
        tbl[1]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0000};
        tbl[2]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 4'b0000};
        tbl[3]  = '{1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 4'b0000};
        tbl[4]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0000};
        tbl[5]  = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0000};
        tbl[6]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0000};
        tbl[7]  = '{1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 4'b0000};
        tbl[8]  = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 4'b1101};
        tbl[9]  = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 4'b1101};
        tbl[10] = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 4'b1101};
        tbl[11] = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 4'b1101};
        tbl[12] = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 4'b1101};
        tbl[13] = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 4'b1101};
        tbl[14] = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 4'b1101};
        tbl[15] = '{1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 4'b1101};

        // reset held for two cycles with start asserted
        rst_n = 1'b0;
        bus1.start = 1'b1;
        bus1.ready = 1'b0;
        bus3.start = 1'b1;
        bus3.ready = 1'b0;
        in1 = 4'b0000;
        in3 = 4'b0000;
        tick();
        tick();
        chk("rst sel",   {30'd0, bus1.s1, bus1.s0}, 32'd0);
        chk("rst busy",  32'(bus1.busy), 32'd0);
        chk("rst valid", 32'(bus1.valid), 32'd0);
        chk("rst data",  32'(bus1.data_out), 32'd0);
        chk("rst state", 32'(dut1.r_state), 32'(ST_IDLE));
        chk("rst3 busy", 32'(bus3.busy), 32'd0);
        rst_n = 1'b1;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
        tick();
        chk("post-rst valid", 32'(bus1.valid), 32'd0);
        chk("post-rst busy",  32'(bus1.busy), 32'd0);

        // nominal scan plus backpressure
        in1 = 4'b1101;
        for (int i = 0; i < 16; i++) begin
            bus1.start = tbl[i].start;
            bus1.ready = tbl[i].ready;
            tick();
            chk($sformatf("vec%0d sel", i),   {30'd0, bus1.s1, bus1.s0}, 32'(tbl[i].sel));
            chk($sformatf("vec%0d busy", i),  32'(bus1.busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d valid", i), 32'(bus1.valid), 32'(tbl[i].valid));
            chk($sformatf("vec%0d data", i),  32'(bus1.data_out), 32'(tbl[i].data));
        end
        chk("bp end state", 32'(dut1.r_state), 32'(ST_IDLE));

        // back-to-back scans with start and ready held high
        t_v1 = -1;
        t_v2 = -1;
        pulses = 0;
        wide = 0;
        prev_v = 1'b0;
        bus1.start = 1'b1;
        bus1.ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus1.valid && prev_v) wide++;
            if (bus1.valid) begin
                pulses++;
                if (t_v1 < 0) begin
                    t_v1 = c;
                    chk("b2b data1", 32'(bus1.data_out), 32'h0000000d);
                    in1 = 4'b0010;
                end else if (t_v2 < 0) begin
                    t_v2 = c;
                    chk("b2b data2", 32'(bus1.data_out), 32'h00000002);
                    bus1.start = 1'b0;
                end
            end
            prev_v = bus1.valid;
        end
        chk("b2b lat1",   32'(t_v1), 32'd8);
        chk("b2b gap",    32'(t_v2 - t_v1), 32'd9);
        chk("b2b pulses", 32'(pulses), 32'd2);
        chk("b2b width",  32'(wide), 32'd0);

        // reset while channel 2 is settling, with start asserted on the reset edge
        in1 = 4'b0110;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        chk("mid sel before rst", {30'd0, bus1.s1, bus1.s0}, 32'd2);
        rst_n = 1'b0;
        bus1.start = 1'b1;
        tick();
        chk("mid rst sel",   {30'd0, bus1.s1, bus1.s0}, 32'd0);
        chk("mid rst busy",  32'(bus1.busy), 32'd0);
        chk("mid rst valid", 32'(bus1.valid), 32'd0);
        chk("mid rst data",  32'(bus1.data_out), 32'd0);
        chk("mid rst state", 32'(dut1.r_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        bus1.start = 1'b0;
        tick();
        chk("mid idle busy", 32'(bus1.busy), 32'd0);
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        lat = -1;
        d_seen = 4'h0;
        for (int c = 1; c < 20; c++) begin
            tick();
            if (bus1.valid && lat < 0) begin
                lat = c;
                d_seen = bus1.data_out;
            end
        end
        chk("mid rescan lat",  32'(lat), 32'd8);
        chk("mid rescan data", 32'(d_seen), 32'h00000006);

        // settle filtering on the SETTLE=3 instance: i0 toggles only while settling
        in3 = 4'b1010;
        bus3.ready = 1'b1;
        bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        lat = -1;
        d_seen = 4'h0;
        for (int c = 1; c < 24; c++) begin
            in3[0] = (c <= 3) ? c[0] : 1'b0;
            tick();
            if (bus3.valid && lat < 0) begin
                lat = c;
                d_seen = bus3.data_out;
            end
        end
        chk("settle3 lat",   32'(lat), 32'd16);
        chk("settle3 data",  32'(d_seen), 32'h0000000a);
        chk("settle3 state", 32'(dut3.r_state), 32'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, meaning the number of cycles to wait after a select change before sampling (legal range 1..15).
REQ-002 Port clk, input, 1, is the single clock; all state updates occur on its rising edge.
REQ-003 Port rst_n, input, 1, is the reset: synchronous and active-low.
REQ-004 Port start, input, 1, requests one 4-channel scan; it is sampled only in IDLE or in DONE during a handshake.
REQ-005 Ports s0 and s1, output, 1 each, drive the 4:1 mux select, encoded as {s1,s0}=channel index.
REQ-006 Port f, input, 1, is the mux output, sampled once per channel.
REQ-007 Port data_out, output, 4, holds the scan result, with bit k equal to f sampled while {s1,s0}=k.
REQ-008 Port valid, output, 1, asserts while data_out holds an unconsumed result.
REQ-009 Port ready, input, 1, is the consumer acceptance; a transfer completes on any edge where valid && ready.
REQ-010 Port busy, output, 1, asserts while a scan is in progress (SETTLE or SAMPLE).

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, SETTLE, SAMPLE and DONE.
REQ-012 IDLE with start=1 SHALL move to SETTLE, set the channel index to 0 and load the settle counter with SETTLE-1.
REQ-013 SETTLE SHALL decrement the counter each cycle and move to SAMPLE on the edge where the counter is 0, so SETTLE lasts exactly SETTLE cycles.
REQ-014 SAMPLE SHALL last exactly one cycle, and on leaving it SHALL write f into shadow bit[channel].
REQ-015 SAMPLE with channel<3 SHALL increment the channel, reload the counter and return to SETTLE.
REQ-016 SAMPLE with channel==3 SHALL, on the same edge, load data_out from the shadow register (including the current f), set valid=1 and enter DONE.
REQ-017 Latency: valid SHALL rise exactly 4*(SETTLE+1) edges after the edge that accepts start (8 edges for SETTLE=1).
REQ-018 The select outputs {s1,s0} SHALL change only on SETTLE entry and remain stable throughout SETTLE and SAMPLE for that channel.
REQ-019 In DONE, data_out and valid SHALL hold while ready=0, with no timeout.
REQ-020 In DONE with ready=1, valid SHALL clear on that edge; with start=1 the FSM SHALL go to SETTLE (back-to-back scan), otherwise to IDLE.
REQ-021 start SHALL be ignored in SETTLE and SAMPLE, and in DONE without ready.
REQ-022 If ready is already high when valid rises, valid SHALL be high for exactly one cycle.
REQ-023 data_out SHALL change only per REQ-016 or on reset, and SHALL retain the last result while in IDLE.
REQ-024 busy SHALL be 1 exactly in SETTLE and SAMPLE.
REQ-025 valid SHALL be 1 exactly in DONE.

Reset
REQ-026 rst_n=0 on an edge SHALL force IDLE, channel=0, s0=s1=0, data_out=0, shadow=0, valid=0, busy=0 and counter=0.
REQ-027 Reset mid-scan or in DONE SHALL discard partial and unconsumed results; no valid SHALL appear until a new start is accepted.
REQ-028 start SHALL be ignored on any edge where rst_n=0.

Structure
REQ-029 A shared package mux_scan_pkg SHALL hold the state typedef (IDLE/SETTLE/SAMPLE/DONE), NUM_CH=4, SEL_W=2 and CNT_W=4.
REQ-030 The settle down-counter SHALL be a sub-module, mux_scan_settle_cnt, with load, dec and zero signals; all other logic stays in mux_scan_ctrl.
REQ-031 The bench SHALL instantiate the existing 4:1 mux stage downstream of s0/s1 and feed its output back to f.

Verification
REQ-032 Reset: hold rst_n=0 for 2 cycles with start=1 -> all outputs 0, state IDLE, no valid afterwards.
REQ-033 Nominal scan: SETTLE=1, i0..i3=1,0,1,1, pulse start -> {s1,s0} steps 00,01,10,11 for 2 cycles each; valid rises 8 edges after start with data_out=4'b1101.
REQ-034 Backpressure: hold ready=0 for 5 cycles after valid and pulse start twice -> data_out=4'b1101 and valid held, start ignored; raise ready -> valid falls next edge and FSM is IDLE.
REQ-035 Back-to-back: SETTLE=1, start and ready held high, then swap inputs to 0,1,0,0 -> valid pulses of one cycle each, 9 cycles apart, values 4'b1101 then 4'b0010.
REQ-036 Mid-scan reset: drop rst_n for 1 cycle while channel=2 -> next edge all reset values, data_out=0; the next start yields a full, correct 8-edge scan.
REQ-037 Settle filtering: SETTLE=3, toggle i0 only during the SETTLE cycles and hold it at 0 during SAMPLE -> data_out[0]=0; valid rises 16 edges after start.
